// File: rtl/led_rate_ctrl.sv
// Speed-select front end for the LED sequencer: debounced up/down keys step a
// 3-bit level that sets the period of a 50%-duty slow clock and its rising-edge tick.
module led_rate_ctrl #(
  parameter int CLK_HZ      = 50_000_000,
  parameter int DB_CYCLES   = 1_000_000,
  parameter int RESET_LEVEL = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_up_n,
  input  logic       key_dn_n,
  output logic [2:0] level,
  output logic       clk_out,
  output logic       tick
);

  localparam int              CNT_W      = $clog2(CLK_HZ / 2);
  localparam int              DB_W       = $clog2(DB_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DB_CYCLES - 1);
  localparam logic [2:0]      LEVEL_INIT = 3'(RESET_LEVEL);

  function automatic logic [2:0] step_level(input logic [2:0] lv,
                                            input logic up, input logic dn);
    step_level = lv;
    if (up && !dn && lv != 3'd7)
      step_level = lv + 3'd1;
    else if (dn && !up && lv != 3'd0)
      step_level = lv - 3'd1;
  endfunction

  function automatic logic [CNT_W-1:0] half_last(input logic [2:0] lv);
    half_last = CNT_W'((CLK_HZ >> (int'(lv) + 1)) - 1);
  endfunction

  // Bit 0 is the up key, bit 1 the down key throughout.
  logic [1:0]      key_raw;
  logic [1:0]      sync_p0, sync_p1;
  logic [1:0]      stable, stable_d, press;
  logic [DB_W-1:0] db_cnt [2];
  logic [CNT_W-1:0] cnt;
  logic [2:0]      level_nxt;
  logic            level_chg;

  assign key_raw = {key_dn_n, key_up_n};

  // Stage p0/p1: two-flop synchroniser, the only consumer of the raw keys
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0 <= 2'b11;
      sync_p1 <= 2'b11;
    end else begin
      sync_p0 <= key_raw;
      sync_p1 <= sync_p0;
    end
  end

  // Debounce and press detect
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable   <= 2'b11;
      stable_d <= 2'b11;
      press    <= 2'b00;
      for (int i = 0; i < 2; i++)
        db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync_p1[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          stable[i] <= sync_p1[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
      stable_d <= stable;
      press    <= stable_d & ~stable;
    end
  end

  assign level_nxt = step_level(level, press[0], press[1]);
  assign level_chg = (level_nxt != level);

  // Level register and rate generator; a level change restarts the half period
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level   <= LEVEL_INIT;
      cnt     <= '0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else begin
      level <= level_nxt;
      if (level_chg) begin
        cnt  <= '0;
        tick <= 1'b0;
      end else if (cnt == half_last(level)) begin
        cnt     <= '0;
        clk_out <= ~clk_out;
        tick    <= ~clk_out;
      end else begin
        cnt  <= cnt + CNT_W'(1);
        tick <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_led_rate_ctrl.sv
// Directed bench for led_rate_ctrl at CLK_HZ=256, DB_CYCLES=4, RESET_LEVEL=2.
module tb_led_rate_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       key_up_n = 1'b1;
  logic       key_dn_n = 1'b1;
  logic [2:0] level;
  logic       clk_out;
  logic       tick;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  led_rate_ctrl #(
    .CLK_HZ     (256),
    .DB_CYCLES  (4),
    .RESET_LEVEL(2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .key_up_n(key_up_n),
    .key_dn_n(key_dn_n),
    .level   (level),
    .clk_out (clk_out),
    .tick    (tick)
  );

  typedef struct {
    logic up;
    logic dn;
    int   hold;
    bit   alt;
    int   exp_level;
    int   exp_period;
  } vec_t;

  vec_t vecs [19];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_tick(input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      step();
      if (tick === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic measure_period(output int p);
    int n;
    wait_tick(600, n);
    if (n < 0) p = -1;
    else wait_tick(600, p);
  endtask

  task automatic do_press(input logic up, input logic dn, input int hold, input bit alt);
    logic prev;
    int   bad;
    bad = 0;
    prev = tick;
    key_up_n = ~up;
    key_dn_n = ~dn;
    for (int i = 0; i < hold; i++) begin
      step();
      if (tick === prev) bad++;
      prev = tick;
    end
    key_up_n = 1'b1;
    key_dn_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      if (tick === prev) bad++;
      prev = tick;
    end
    if (alt) chk("sat_tick_alternates", bad, 0);
  endtask

  // Checks the first period after reset release: rise on edge 32, high 32, period 64.
  task automatic post_reset_timing(input string tag);
    int n;
    int hi;
    int tick_after;
    wait_tick(100, n);
    chk({tag, "_first_tick_edge"}, n, 32);
    chk({tag, "_clk_out_at_tick"}, int'(clk_out), 1);
    hi = -1;
    tick_after = -1;
    for (int i = 1; i <= 100; i++) begin
      step();
      if (i == 1) tick_after = int'(tick);
      if (clk_out === 1'b0) begin
        hi = i;
        break;
      end
    end
    chk({tag, "_tick_one_cycle"}, tick_after, 0);
    chk({tag, "_high_cycles"}, hi, 32);
    wait_tick(100, n);
    chk({tag, "_low_then_tick"}, n, 32);
    wait_tick(100, n);
    chk({tag, "_period"}, n, 64);
  endtask

  initial begin
    int n;
    int lat;
    logic c;

    vecs[0]  = '{1'b1, 1'b0, 12, 1'b0, 4, 16};
    vecs[1]  = '{1'b1, 1'b0, 12, 1'b0, 5, 8};
    vecs[2]  = '{1'b1, 1'b0, 12, 1'b0, 6, 4};
    vecs[3]  = '{1'b1, 1'b0, 12, 1'b0, 7, 2};
    vecs[4]  = '{1'b1, 1'b0, 12, 1'b1, 7, 2};
    vecs[5]  = '{1'b0, 1'b1, 12, 1'b0, 6, 4};
    vecs[6]  = '{1'b0, 1'b1, 12, 1'b0, 5, 8};
    vecs[7]  = '{1'b0, 1'b1, 12, 1'b0, 4, 16};
    vecs[8]  = '{1'b0, 1'b1, 12, 1'b0, 3, 32};
    vecs[9]  = '{1'b0, 1'b1, 12, 1'b0, 2, 64};
    vecs[10] = '{1'b0, 1'b1, 12, 1'b0, 1, 128};
    vecs[11] = '{1'b0, 1'b1, 12, 1'b0, 0, 256};
    vecs[12] = '{1'b0, 1'b1, 12, 1'b0, 0, 256};
    vecs[13] = '{1'b1, 1'b0, 12, 1'b0, 1, 128};
    vecs[14] = '{1'b1, 1'b0, 12, 1'b0, 2, 64};
    vecs[15] = '{1'b1, 1'b0, 12, 1'b0, 3, 32};
    vecs[16] = '{1'b1, 1'b1, 20, 1'b0, 3, 32};
    vecs[17] = '{1'b1, 1'b0, 12, 1'b0, 4, 16};
    vecs[18] = '{1'b1, 1'b0, 12, 1'b0, 5, 8};

    // Scenario 1: asynchronous reset and default rate
    #1 rst = 1'b1;
    #1;
    chk("rst_level", int'(level), 2);
    chk("rst_clk_out", int'(clk_out), 0);
    chk("rst_tick", int'(tick), 0);
    repeat (3) step();
    rst = 1'b0;
    post_reset_timing("s1");

    // Scenario 2: short bounce ignored, then a held press steps once
    key_up_n = 1'b0;
    repeat (2) step();
    key_up_n = 1'b1;
    repeat (15) step();
    chk("bounce_level", int'(level), 2);

    key_up_n = 1'b0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (level !== 3'd2) begin
        lat = i;
        break;
      end
    end
    chk("press_latency", lat, 8);
    chk("press_level", int'(level), 3);
    c = clk_out;
    wait_tick(100, n);
    chk("restart_first_tick", n, (c === 1'b1) ? 32 : 16);
    repeat (400) step();
    chk("held_no_repeat", int'(level), 3);
    key_up_n = 1'b1;
    repeat (12) step();
    measure_period(n);
    chk("lvl3_period", n, 32);

    // Scenarios 3-5: table of presses with level and tick period after each
    for (int i = 0; i < 19; i++) begin
      do_press(vecs[i].up, vecs[i].dn, vecs[i].hold, vecs[i].alt);
      chk($sformatf("v%0d_level", i), int'(level), vecs[i].exp_level);
      measure_period(n);
      chk($sformatf("v%0d_period", i), n, vecs[i].exp_period);
    end

    // Scenario 6: reset between clock edges while clk_out is high at level 5
    n = -1;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (clk_out === 1'b1) begin
        n = i;
        break;
      end
    end
    chk("l5_found_high", int'(n > 0), 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_level", int'(level), 2);
    chk("async_rst_clk_out", int'(clk_out), 0);
    chk("async_rst_tick", int'(tick), 0);
    #2 rst = 1'b0;
    post_reset_timing("s6");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
